// File: rtl/ternary_pkg.sv
// Shared types for the balanced-ternary CPU and its performance monitor.
package ternary_pkg;

    typedef enum logic [1:0] {
        PERF_IDLE   = 2'd0,
        PERF_RUN    = 2'd1,
        PERF_FROZEN = 2'd2
    } perf_state_t;

    // Counter 0 is the cycle counter; event_i[k] feeds counter k+1.
    localparam int PERF_IDX_CYCLE  = 0;
    localparam int PERF_IDX_RETIRE = 1;
    localparam int PERF_IDX_STALL  = 2;
    localparam int PERF_IDX_FWD    = 3;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter; bumped is value plus this cycle's increment, used for window snapshots.
module perf_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    input  logic                 zero,
    output logic [CNT_WIDTH-1:0] value,
    output logic [CNT_WIDTH-1:0] bumped,
    output logic                 sat_attempt
);

    logic [CNT_WIDTH-1:0] value_q, value_d;
    logic                 at_max;

    assign at_max      = &value_q;
    assign sat_attempt = inc && at_max;
    assign bumped      = (inc && !at_max) ? value_q + CNT_WIDTH'(1) : value_q;
    assign value       = value_q;

    always_comb begin
        value_d = bumped;
        if (clear || zero) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/ternary_perf_monitor.sv
// Performance monitor beside ternary_cpu: cycle/event counters, freeze-on-halt,
// windowed snapshots and a registered readback port.
module ternary_perf_monitor
    import ternary_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int IDX_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  halt_i,
    input  logic                  win_en_i,
    input  logic [CNT_WIDTH-1:0]  win_len_i,
    input  logic                  rd_req_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    input  logic                  rd_shadow_i,
    output logic                  rd_valid_o,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic                  rd_err_o,
    output logic [NUM_EVENTS:0]   ovf_o,
    output logic                  snap_o,
    output logic [1:0]            state_o
);

    localparam int NC = NUM_EVENTS + 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_EVENTS);

    perf_state_t          state_q, state_d;
    logic                 halt_q, halt_d;
    logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_WIDTH-1:0] shadow_q [NC];
    logic [CNT_WIDTH-1:0] shadow_d [NC];
    logic [CNT_WIDTH-1:0] live     [NC];
    logic [CNT_WIDTH-1:0] bumped   [NC];
    logic [NC-1:0]        inc, sat_attempt;
    logic [NC-1:0]        ovf_q, ovf_d;
    logic                 snap_q, snap_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 halt_rise, count_en, win_active, boundary;

    // The cycle a halt edge is seen is not counted; the freeze takes precedence.
    assign halt_rise  = halt_i && !halt_q;
    assign count_en   = (state_q == PERF_RUN) && !halt_rise && !clear_i;
    assign inc        = {event_i, 1'b1} & {NC{count_en}};
    assign win_active = win_en_i && (win_len_i != '0) && (state_q == PERF_RUN);
    assign boundary   = win_active && !clear_i && (win_cnt_q >= win_len_i - CNT_WIDTH'(1));
    assign halt_d     = halt_i;

    for (genvar i = 0; i < NC; i++) begin : g_cnt
        perf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (clear_i),
            .inc         (inc[i]),
            .zero        (boundary),
            .value       (live[i]),
            .bumped      (bumped[i]),
            .sat_attempt (sat_attempt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = PERF_IDLE;
        end else begin
            case (state_q)
                PERF_IDLE:   if (en_i) state_d = PERF_RUN;
                PERF_RUN: begin
                    if (halt_rise)  state_d = PERF_FROZEN;
                    else if (!en_i) state_d = PERF_IDLE;
                end
                PERF_FROZEN: state_d = PERF_FROZEN;
                default:     state_d = PERF_IDLE;
            endcase
        end
    end

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (clear_i || boundary) begin
            win_cnt_d = '0;
        end else if (win_active && !halt_rise) begin
            win_cnt_d = win_cnt_q + CNT_WIDTH'(1);
        end
        for (int i = 0; i < NC; i++) begin
            shadow_d[i] = shadow_q[i];
            if (clear_i)       shadow_d[i] = '0;
            else if (boundary) shadow_d[i] = bumped[i];
        end
        ovf_d  = clear_i ? '0 : (ovf_q | sat_attempt);
        snap_d = boundary;
    end

    // Readback samples the pre-edge counter values; clear does not cancel it.
    always_comb begin
        rd_valid_d = rd_req_i;
        rd_err_d   = rd_req_i && (rd_idx_i > MAX_IDX);
        rd_data_d  = '0;
        if (rd_req_i && (rd_idx_i <= MAX_IDX)) begin
            rd_data_d = rd_shadow_i ? shadow_q[rd_idx_i] : live[rd_idx_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PERF_IDLE;
            halt_q     <= 1'b0;
            win_cnt_q  <= '0;
            ovf_q      <= '0;
            snap_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < NC; i++) shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            win_cnt_q  <= win_cnt_d;
            ovf_q      <= ovf_d;
            snap_q     <= snap_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            shadow_q   <= shadow_d;
        end
    end

    assign state_o    = state_q;
    assign ovf_o      = ovf_q;
    assign snap_o     = snap_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;

endmodule
